// File: rtl/operand_fetch_pkg.sv
// Shared core definitions for the operand-fetch stage: default register-file
// geometry and the register address type.
package operand_fetch_pkg;

   localparam int RegWidthDefault = 32;
   localparam int RegDepthDefault = 32;
   localparam int RegAddrWidth    = $clog2(RegDepthDefault);

   typedef logic [RegAddrWidth-1:0] reg_addr_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register 1..RegDepth-1, x0 never pending.
// A set and a clear of the same register in one cycle leaves the bit set.
module scoreboard
   import operand_fetch_pkg::*;
#(
   parameter int RegDepth = RegDepthDefault,
   localparam int AW      = $clog2(RegDepth)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                set_en_i,
   input  logic [AW-1:0]       set_addr_i,
   input  logic [RegDepth-1:0] clr_vec_i,
   output logic [RegDepth-1:0] pending_o
);

   logic [RegDepth-1:1] pending_q;
   logic [RegDepth-1:1] pending_d;

   for (genvar gi = 1; gi < RegDepth; gi++) begin : g_bit
      assign pending_d[gi] = (set_en_i && (set_addr_i == AW'(gi)))
                          || (pending_q[gi] && !clr_vec_i[gi]);

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            pending_q[gi] <= 1'b0;
         end else begin
            pending_q[gi] <= pending_d[gi];
         end
      end
   end

   assign pending_o = {pending_q, 1'b0};

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: single-entry pipeline register that reads the register
// file, bypasses same-cycle writeback, and stalls on RAW/WAW against pending writes.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int RegWidth = RegWidthDefault,
   parameter int RegDepth = RegDepthDefault,
   localparam int AW      = $clog2(RegDepth)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [RegWidth-1:0] in_pc_i,
   input  logic [AW-1:0]       in_rs1_addr_i,
   input  logic [AW-1:0]       in_rs2_addr_i,
   input  logic [AW-1:0]       in_rd_addr_i,
   input  logic                in_rd_wen_i,
   output logic [AW-1:0]       rf_rs1_addr_o,
   output logic [AW-1:0]       rf_rs2_addr_o,
   input  logic [RegWidth-1:0] rf_rs1_data_i,
   input  logic [RegWidth-1:0] rf_rs2_data_i,
   input  logic                wb_valid_i,
   input  logic [AW-1:0]       wb_rd_addr_i,
   input  logic [RegWidth-1:0] wb_rd_data_i,
   input  logic                flush_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [RegWidth-1:0] out_pc_o,
   output logic [RegWidth-1:0] out_rs1_data_o,
   output logic [RegWidth-1:0] out_rs2_data_o,
   output logic [AW-1:0]       out_rd_addr_o,
   output logic                out_rd_wen_o
);

   logic                valid_q;
   logic [RegWidth-1:0] pc_q, op1_q, op2_q;
   logic [AW-1:0]       rd_q;
   logic                rd_wen_q;
   logic [RegWidth-1:0] op1_d, op2_d;

   logic [RegDepth-1:0] pending;
   logic [RegDepth-1:0] wb_clr_vec, flush_clr_vec, live;
   logic                hazard, accept, issue, set_en;

   assign rf_rs1_addr_o = in_rs1_addr_i;
   assign rf_rs2_addr_o = in_rs2_addr_i;

   for (genvar gi = 0; gi < RegDepth; gi++) begin : g_clr
      assign wb_clr_vec[gi]    = wb_valid_i && (wb_rd_addr_i == AW'(gi));
      assign flush_clr_vec[gi] = flush_i && valid_q && rd_wen_q && (rd_q == AW'(gi));
   end

   // A register whose writeback commits this cycle no longer blocks: its data is bypassed.
   assign live   = pending & ~wb_clr_vec;
   assign hazard = in_valid_i && (live[in_rs1_addr_i] || live[in_rs2_addr_i]
                               || (in_rd_wen_i && live[in_rd_addr_i]));

   assign in_ready_o = !rst_i && (!valid_q || out_ready_i) && !hazard && !flush_i;
   assign accept     = in_valid_i && in_ready_o;
   assign issue      = valid_q && out_ready_i && !flush_i;
   assign set_en     = accept && in_rd_wen_i && (in_rd_addr_i != '0);

   always_comb begin
      op1_d = rf_rs1_data_i;
      op2_d = rf_rs2_data_i;
      if (in_rs1_addr_i == '0) begin
         op1_d = '0;
      end else if (wb_valid_i && (wb_rd_addr_i == in_rs1_addr_i)) begin
         op1_d = wb_rd_data_i;
      end
      if (in_rs2_addr_i == '0) begin
         op2_d = '0;
      end else if (wb_valid_i && (wb_rd_addr_i == in_rs2_addr_i)) begin
         op2_d = wb_rd_data_i;
      end
   end

   scoreboard #(
      .RegDepth (RegDepth)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .set_en_i   (set_en),
      .set_addr_i (in_rd_addr_i),
      .clr_vec_i  (wb_clr_vec | flush_clr_vec),
      .pending_o  (pending)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         rd_q     <= '0;
         rd_wen_q <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q  <= 1'b1;
         pc_q     <= in_pc_i;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         rd_q     <= in_rd_addr_i;
         rd_wen_q <= in_rd_wen_i;
      end else if (issue) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o    = valid_q;
   assign out_pc_o       = pc_q;
   assign out_rs1_data_o = op1_q;
   assign out_rs2_data_o = op2_q;
   assign out_rd_addr_o  = rd_q;
   assign out_rd_wen_o   = rd_wen_q;

endmodule
